// File: rtl/spmv_pkg.sv
// rtl/spmv_pkg.sv - shared spmv definitions: loader FSM states and bank-select constants
//
// Contents:
//   ld_state_t     : ping-pong cache loader FSM states
//   INIT_SELECT    : bank driven on the select pulse issued by INIT
//   INIT_FILL_BANK : bank filled first after INIT (the one not selected)
package spmv_pkg;

    typedef enum logic [2:0] {
        ST_INIT       = 3'd0,
        ST_IDLE       = 3'd1,
        ST_FILL       = 3'd2,
        ST_WAIT_DRAIN = 3'd3,
        ST_SWAP       = 3'd4
    } ld_state_t;

    localparam logic INIT_SELECT    = 1'b0;
    localparam logic INIT_FILL_BANK = 1'b1;

endpackage

// File: rtl/ppcache_loader.sv
// rtl/ppcache_loader.sv - segment loader that fills one ping-pong cache bank and swaps banks
//
// Ports:
//   clk, rst                             : clock, synchronous active-high reset
//   seg_vaild/seg_ready/seg_len          : segment descriptor (length in beats)
//   src_vaild/src_ready/src_data         : upstream data stream
//   select_vaild/select                  : bank-swap command to the cache
//   input_vaild/input_ready/input_data   : cache write side (combinational pass-through in FILL)
//   drain_done                           : consumer pulse, active bank fully read
//   fill_bank, err                       : bank being filled, sticky error flag
//   seg_cnt, stall_cnt                   : performance counters
//
// Macro PPCACHE_LOADER_PERF_CNT_EN: when defined, seg_cnt/stall_cnt are live
// counters; otherwise both are constant 0.
module ppcache_loader
    import spmv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  seg_vaild,
    output logic                  seg_ready,
    input  logic [ADDR_WIDTH:0]   seg_len,
    input  logic                  src_vaild,
    output logic                  src_ready,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  select_vaild,
    output logic                  select,
    output logic                  input_vaild,
    input  logic                  input_ready,
    output logic [DATA_WIDTH-1:0] input_data,
    input  logic                  drain_done,
    output logic                  fill_bank,
    output logic                  err,
    output logic [31:0]           seg_cnt,
    output logic [31:0]           stall_cnt
);

    localparam logic [ADDR_WIDTH:0] LP_MAX_LEN = (ADDR_WIDTH + 1)'(DATA_DEPTH);

    ld_state_t           r_state;
    logic                r_fill_bank;
    logic                r_busy;
    logic                r_err;
    logic                r_sel_vld;
    logic                r_sel;
    logic                r_seg_rdy;
    logic [ADDR_WIDTH:0] r_len;
    logic [ADDR_WIDTH:0] r_beat_cnt;

    logic                w_in_fill;
    logic                w_beat;
    logic                w_seg_take;
    logic                w_len_ok;
    logic [ADDR_WIDTH:0] w_cnt_next;

    // Stream path is gated by rst so a reset mid-FILL cuts input_vaild at once.
    assign w_in_fill  = !rst && (r_state == ST_FILL);
    assign w_beat     = w_in_fill && src_vaild && input_ready;
    assign w_seg_take = seg_vaild && seg_ready;
    assign w_len_ok   = (seg_len != '0) && (seg_len <= LP_MAX_LEN);
    assign w_cnt_next = r_beat_cnt + 1'b1;

    assign seg_ready    = r_seg_rdy && !rst;
    assign src_ready    = w_in_fill && input_ready;
    assign input_vaild  = w_in_fill && src_vaild;
    assign input_data   = src_data;
    assign select_vaild = r_sel_vld && !rst;
    assign select       = r_sel;
    assign fill_bank    = r_fill_bank;
    assign err          = r_err;

    // select_vaild/select/seg_ready are registered: they are set on the
    // transition into INIT/SWAP/IDLE and cleared on the way out. Reset preloads
    // the INIT select pulse so it appears on the first cycle after release.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_fill_bank <= INIT_FILL_BANK;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_len       <= '0;
            r_beat_cnt  <= '0;
            r_sel_vld   <= 1'b1;
            r_sel       <= INIT_SELECT;
            r_seg_rdy   <= 1'b0;
        end else begin
            // A drain with nothing outstanding is a protocol error. In SWAP the
            // set below wins, so a drain there leaves busy at 1.
            if (drain_done) begin
                if (!r_busy) begin
                    r_err <= 1'b1;
                end
                if (r_state != ST_SWAP) begin
                    r_busy <= 1'b0;
                end
            end

            case (r_state)
                ST_INIT: begin
                    r_fill_bank <= INIT_FILL_BANK;
                    r_busy      <= 1'b0;
                    r_sel_vld   <= 1'b0;
                    r_seg_rdy   <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (w_seg_take) begin
                        if (w_len_ok) begin
                            r_len      <= seg_len;
                            r_beat_cnt <= '0;
                            r_seg_rdy  <= 1'b0;
                            r_state    <= ST_FILL;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    if (w_beat) begin
                        r_beat_cnt <= w_cnt_next;
                        if (w_cnt_next == r_len) begin
                            r_state <= ST_WAIT_DRAIN;
                        end
                    end
                end
                ST_WAIT_DRAIN: begin
                    if (!r_busy || drain_done) begin
                        r_sel_vld <= 1'b1;
                        r_sel     <= r_fill_bank;
                        r_state   <= ST_SWAP;
                    end
                end
                ST_SWAP: begin
                    r_sel_vld   <= 1'b0;
                    r_fill_bank <= ~r_fill_bank;
                    r_busy      <= 1'b1;
                    r_seg_rdy   <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_sel_vld <= 1'b1;
                    r_sel     <= INIT_SELECT;
                    r_seg_rdy <= 1'b0;
                    r_state   <= ST_INIT;
                end
            endcase
        end
    end

`ifdef PPCACHE_LOADER_PERF_CNT_EN
    logic [31:0] r_seg_cnt;
    logic [31:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = (r_state == ST_WAIT_DRAIN) ||
                     ((r_state == ST_FILL) && src_vaild && !input_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (r_state == ST_SWAP) begin
                r_seg_cnt <= r_seg_cnt + 32'd1;
            end
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign seg_cnt   = r_seg_cnt;
    assign stall_cnt = r_stall_cnt;
`else
    assign seg_cnt   = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: doc/ppcache_loader.md
PPCACHE_LOADER -- requirements
Module: ppcache_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the data beat width.
REQ-002 SHALL have parameter DATA_DEPTH, default 1024, the words per ping-pong bank.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, where log2(DATA_DEPTH) equals ADDR_WIDTH.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have ports seg_vaild (in, 1), seg_ready (out, 1) and seg_len (in, ADDR_WIDTH+1): the segment descriptor, whose length is in beats.
REQ-007 SHALL have ports src_vaild (in, 1), src_ready (out, 1) and src_data (in, DATA_WIDTH): the upstream data stream.
REQ-008 SHALL have ports select_vaild (out, 1) and select (out, 1): the bank-swap command to the ping-pong cache.
REQ-009 SHALL have ports input_vaild (out, 1), input_ready (in, 1) and input_data (out, DATA_WIDTH): the cache write side.
REQ-010 SHALL have port drain_done, input, 1 bit: a one-cycle pulse from the consumer meaning the active bank is fully read.
REQ-011 SHALL have ports fill_bank (out, 1) and err (out, 1, sticky): the bank currently being filled, and the error flag.
REQ-012 SHALL have ports seg_cnt (out, 32) and stall_cnt (out, 32): the performance counters (see Configuration).

Function
REQ-013 SHALL implement the FSM states INIT, IDLE, FILL, WAIT_DRAIN and SWAP, plus a busy flag that marks the active bank as unread.
REQ-014 SHALL in INIT assert select_vaild=1 and select=0 for exactly one cycle, set fill_bank=1 and busy=0, then go to IDLE.
REQ-015 SHALL in IDLE hold seg_ready=1; on seg_vaild&seg_ready with 1<=seg_len<=DATA_DEPTH it SHALL latch the length, clear the beat count and go to FILL.
REQ-016 SHALL on an accepted seg_len of 0 or greater than DATA_DEPTH set err, drop the descriptor and stay in IDLE.
REQ-017 SHALL in FILL drive src_ready=input_ready, input_vaild=src_vaild and input_data=src_data combinationally, with zero added latency; outside FILL, src_ready=0 and input_vaild=0.
REQ-018 SHALL count one beat per cycle where src_vaild&input_ready in FILL, and on the beat that brings the count to the latched length go to WAIT_DRAIN.
REQ-019 SHALL in WAIT_DRAIN go to SWAP in the same cycle that busy==0, or that busy==1 and drain_done==1.
REQ-020 SHALL in SWAP assert select_vaild=1 and select=fill_bank for one cycle; next state it SHALL toggle fill_bank, set busy=1 and go to IDLE.
REQ-021 SHALL clear busy on drain_done in any state other than SWAP; a drain_done in SWAP is applied before the set, so busy ends at 1.
REQ-022 SHALL set err on drain_done while busy==0 and otherwise ignore that pulse.
REQ-023 SHALL never assert select_vaild and input_vaild in the same cycle.
REQ-024 SHALL keep the beat counter ADDR_WIDTH+1 bits wide so that a length of DATA_DEPTH does not wrap.

Reset
REQ-025 SHALL on rst=1 set state=INIT, fill_bank=1, busy=0, err=0, beat count 0, seg_cnt=0 and stall_cnt=0.
REQ-026 SHALL during reset drive seg_ready, src_ready, input_vaild and select_vaild to 0.
REQ-027 SHALL on reset asserted mid-FILL abort the segment with no further input_vaild, and then re-run INIT.

Configuration
REQ-028 SHALL, when macro PPCACHE_LOADER_PERF_CNT_EN is defined, increment seg_cnt once per SWAP and increment stall_cnt each cycle spent in WAIT_DRAIN or in FILL with src_vaild&!input_ready, both wrapping at 2^32.
REQ-029 SHALL, when PPCACHE_LOADER_PERF_CNT_EN is undefined, tie seg_cnt and stall_cnt to constant 0 with no counter flops.

Structure
REQ-030 SHALL take the FSM state enum and the swap/INIT select constants from the shared spmv package.
REQ-031 SHALL be a single module with no sub-modules, since the FSM and counters are flat.

Verification
REQ-032 SHALL verify: release rst -> INIT pulses select_vaild=1, select=0 for one cycle; fill_bank=1.
REQ-033 SHALL verify: seg_len=4 with 4 src beats and input_ready=1 -> 4 input_vaild beats, then a SWAP with select=1 on the next cycle, fill_bank=0.
REQ-034 SHALL verify: second seg_len=3 filled while busy=1 -> stays in WAIT_DRAIN until drain_done, then SWAP with select=0 in that cycle.
REQ-035 SHALL verify: input_ready toggling 1,0,1,0 during seg_len=2 -> src_ready tracks it, 2 beats are accepted, and stall_cnt=2 with the macro defined.
REQ-036 SHALL verify: seg_len=0, then seg_len=DATA_DEPTH+1 -> err=1, no FILL entered; then seg_len=DATA_DEPTH -> 1024 beats accepted with no counter wrap.
REQ-037 SHALL verify: rst asserted after 2 of 5 beats -> input_vaild=0 next cycle, then the INIT select pulse recurs.
